// File: rtl/approx_operand_encoder_pkg.sv
// approx_operand_encoder_pkg: shared widths and FSM encoding for the PU operand encoder
package approx_operand_encoder_pkg;
  localparam int IN_WIDTH = 7;
  localparam int MANT = 2;
  localparam int EXPW = $clog2(IN_WIDTH + 1);
  localparam int XLEN = EXPW + MANT;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FULL = 2'd2
  } state_t;
endpackage

// File: rtl/lod_scan_step.sv
// lod_scan_step: one leading-one scan step; ports sh/cnt in, sh_n/cnt_n/done/code out
module lod_scan_step
  import approx_operand_encoder_pkg::*;
(
  input  logic [IN_WIDTH-1:0] sh,
  input  logic [EXPW-1:0]     cnt,
  output logic [IN_WIDTH-1:0] sh_n,
  output logic [EXPW-1:0]     cnt_n,
  output logic                done,
  output logic [XLEN-1:0]     code
);
  assign done  = (cnt == '0) || sh[IN_WIDTH-1];
  assign sh_n  = sh << 1;
  assign cnt_n = cnt - 1'b1;
  assign code  = {cnt, sh[IN_WIDTH-2 -: MANT]};
endmodule

// File: rtl/approx_operand_encoder.sv
// approx_operand_encoder: encodes samples to {exp,mant} and packs four into num1..num4; ports in_valid/in_data/in_ready in, out_valid/out_ready/num1..num4 out, busy
module approx_operand_encoder
  import approx_operand_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     num1,
  output logic [XLEN-1:0]     num2,
  output logic [XLEN-1:0]     num3,
  output logic [XLEN-1:0]     num4,
  output logic                busy
);
  state_t state, state_n;
  logic [1:0] idx;
  logic [IN_WIDTH-1:0] sh, sh_n;
  logic [EXPW-1:0] cnt, cnt_n;
  logic done;
  logic [XLEN-1:0] code;
  logic [XLEN-1:0] num [4];
  lod_scan_step u_step (
    .sh    (sh),
    .cnt   (cnt),
    .sh_n  (sh_n),
    .cnt_n (cnt_n),
    .done  (done),
    .code  (code)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (in_ready && in_valid) ? SCAN : IDLE;
      SCAN:    state_n = done ? ((idx == 2'd3) ? FULL : IDLE) : SCAN;
      FULL:    state_n = out_ready ? IDLE : FULL;
      default: state_n = IDLE;
    endcase
  end
  // Handshake flags are registered from the next state so they stay low while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      sh        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 4; i++) num[i] <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == FULL);
      busy      <= (state_n == SCAN);
      if (state == IDLE && in_ready && in_valid) begin
        sh  <= in_data;
        cnt <= EXPW'(IN_WIDTH);
      end
      if (state == SCAN) begin
        if (done) begin
          num[idx] <= code;
          idx      <= (idx == 2'd3) ? idx : idx + 2'd1;
        end else begin
          sh  <= sh_n;
          cnt <= cnt_n;
        end
      end
      if (state == FULL && out_ready) idx <= '0;
    end
  end
  assign num1 = num[0];
  assign num2 = num[1];
  assign num3 = num[2];
  assign num4 = num[3];
endmodule

// File: tb/tb_approx_operand_encoder.sv
// tb_approx_operand_encoder: directed and random checks of the operand encoder against a code-rule model
module tb_approx_operand_encoder;
  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [6:0] in_data;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [4:0] num1, num2, num3, num4;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q [$];

  approx_operand_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .num4      (num4),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // exp = bit length of x, mant = next two bits below the leading one (zero padded)
  function automatic logic [4:0] ref_code(input int x);
    int e, p, m;
    if (x == 0) return 5'd0;
    e = $clog2(x + 1);
    p = e - 1;
    m = (p >= 2) ? ((x >> (p - 2)) & 3) : ((x << (2 - p)) & 3);
    return {e[2:0], m[1:0]};
  endfunction

  function automatic int ref_lat(input int x);
    return 8 - $clog2(x + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input logic [4:0] e1, e2, e3, e4);
    chk({tag, ".num1"}, 32'(num1), 32'(e1));
    chk({tag, ".num2"}, 32'(num2), 32'(e2));
    chk({tag, ".num3"}, 32'(num3), 32'(e3));
    chk({tag, ".num4"}, 32'(num4), 32'(e4));
  endtask

  // Called at a negedge; returns at the negedge where busy has dropped.
  task automatic send(input logic [6:0] x, output int scans);
    int w;
    in_data  = x;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 7'($urandom);
    scans = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      scans++;
    end
    if (busy) chk("scan_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int s;
    logic [6:0] x;
    logic [4:0] e1, e2, e3, e4;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk_bundle("rst", 5'd0, 5'd0, 5'd0, 5'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    send(7'b1011010, s);
    chk("t1.lat90", 32'(s), 32'd1);
    chk("t1.num1", 32'(num1), 32'b11101);
    send(7'b0000011, s);
    chk("t1.lat3", 32'(s), 32'd6);
    chk("t1.num2", 32'(num2), 32'b01010);
    send(7'd0, s);
    chk("t2.lat0", 32'(s), 32'd8);
    chk("t2.num3", 32'(num3), 32'b00000);
    send(7'd1, s);
    chk("t2.lat1", 32'(s), 32'd7);
    chk("t2.num4", 32'(num4), 32'b00100);
    chk("t2.out_valid", 32'(out_valid), 32'd1);
    chk("t2.in_ready", 32'(in_ready), 32'd0);
    consume();

    send(7'd90, s);
    send(7'd12, s);
    send(7'd1, s);
    send(7'd0, s);
    wait_ov();
    chk_bundle("t3", 5'b11101, 5'b10010, 5'b00100, 5'b00000);

    in_valid = 1'b1;
    in_data = 7'd55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4.hold_valid", 32'(out_valid), 32'd1);
      chk("t4.hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk_bundle("t4.hold", 5'b11101, 5'b10010, 5'b00100, 5'b00000);
    consume();
    chk("t4.in_ready", 32'(in_ready), 32'd1);
    chk("t4.out_valid", 32'(out_valid), 32'd0);
    chk_bundle("t4.kept", 5'b11101, 5'b10010, 5'b00100, 5'b00000);

    send(7'd5, s);
    send(7'd6, s);
    in_data = 7'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5.rst_busy", 32'(busy), 32'd0);
    chk("t5.rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5.rst_out_valid", 32'(out_valid), 32'd0);
    chk_bundle("t5.rst", 5'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(7'd100, s);
    send(7'd7, s);
    chk("t5.no_early_valid", 32'(out_valid), 32'd0);
    send(7'd64, s);
    send(7'd33, s);
    wait_ov();
    chk_bundle("t5.fresh", ref_code(100), ref_code(7), ref_code(64), ref_code(33));
    consume();

    for (int b = 0; b < 250; b++) begin
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        x = 7'($urandom_range(0, 127));
        exp_q.push_back(ref_code(int'(x)));
        send(x, s);
        chk("rnd.lat", 32'(s), 32'(ref_lat(int'(x))));
      end
      wait_ov();
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd.hold", 32'(out_valid), 32'd1);
      end
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      e3 = exp_q.pop_front();
      e4 = exp_q.pop_front();
      chk_bundle("rnd", e1, e2, e3, e4);
      consume();
      chk("rnd.released", 32'(out_valid), 32'd0);
    end
    chk("rnd.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
